// File: rtl/rf_seq_multiplier_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rf_mul_pkg : shared widths and FSM encoding for rf_seq_multiplier        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package rf_mul_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    // Must hold the value DATA_W, reached after the final step
    localparam int CNT_W  = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MUL   = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4,
        DONE  = 3'd5
    } state_e;

endpackage
`default_nettype wire

// File: rtl/rf_seq_multiplier_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rf_mul_if : request side and register-file port bundle of the multiplier |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface rf_mul_if;
    import rf_mul_pkg::*;

    logic              start;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [ADDR_W-1:0] rd_lo;
    logic [ADDR_W-1:0] rd_hi;
    logic [ADDR_W-1:0] RX;
    logic [ADDR_W-1:0] RY;
    logic [DATA_W-1:0] busX;
    logic [DATA_W-1:0] busY;
    logic              WEN;
    logic [ADDR_W-1:0] RW;
    logic [DATA_W-1:0] busW;
    logic              busy;
    logic              done;

    modport master (
        input  start, rs, rt, rd_lo, rd_hi, busX, busY,
        output RX, RY, WEN, RW, busW, busy, done
    );

    modport slave (
        output start, rs, rt, rd_lo, rd_hi, busX, busY,
        input  RX, RY, WEN, RW, busW, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/rf_seq_multiplier_shift_add.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | shift_add_unit : mcand/acc/mplier datapath, one add-shift step per cycle |
// | Option MUL_EARLY_TERM_EN adds zero_left and product realignment. Rev 1.0 |
// +--------------------------------------------------------------------------+
module shift_add_unit
    import rf_mul_pkg::*;
(
    input  wire logic                Clk,
    input  wire logic                Rst,
    input  wire logic                load,
    input  wire logic                step,
    input  wire logic [DATA_W-1:0]   mcandIn,
    input  wire logic [DATA_W-1:0]   mplierIn,
    output logic                     lastStep,
    output logic                     zero_left,
    output logic [2*DATA_W-1:0]      product
);

    logic [DATA_W-1:0]   r_mcand;
    logic [DATA_W-1:0]   r_acc;
    logic [DATA_W-1:0]   r_mplier;
    logic [CNT_W-1:0]    r_count;
    logic [DATA_W:0]     w_sum;
    logic [2*DATA_W-1:0] w_chain;

    assign w_sum   = {1'b0, r_acc} + (r_mplier[0] ? {1'b0, r_mcand} : '0);
    assign w_chain = {r_acc, r_mplier};

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_count  <= '0;
        end else if (load) begin
            r_mcand  <= mcandIn;
            r_acc    <= '0;
            r_mplier <= mplierIn;
            r_count  <= '0;
        end else if (step) begin
            // Carry enters the top of acc, acc LSB enters the top of mplier
            r_acc    <= w_sum[DATA_W:1];
            r_mplier <= {w_sum[0], r_mplier[DATA_W-1:1]};
            r_count  <= r_count + 1'b1;
        end
    end

    assign lastStep = (r_count == CNT_W'(DATA_W - 1));

`ifdef MUL_EARLY_TERM_EN
    logic [DATA_W-1:0] w_remBits;

    // Low DATA_W-count bits of mplier still hold unconsumed multiplier bits
    assign w_remBits = r_mplier & ({DATA_W{1'b1}} >> r_count);
    assign zero_left = (w_remBits[DATA_W-1:1] == '0);
    // Skipped steps would only have shifted; apply them in one go
    assign product   = w_chain >> (CNT_W'(DATA_W) - r_count);
`else
    assign zero_left = 1'b0;
    assign product   = w_chain;
`endif

endmodule
`default_nettype wire

// File: rtl/rf_seq_multiplier.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rf_seq_multiplier : shift-add multiplier reading/writing the 8x8 regfile |
// | Option MUL_EARLY_TERM_EN ends MUL once multiplier bits run out. Rev 1.0  |
// +--------------------------------------------------------------------------+
module rf_seq_multiplier
    import rf_mul_pkg::*;
(
    input  wire logic Clk,
    input  wire logic Rst,
    rf_mul_if.master  bus
);

    state_e              r_state;
    state_e              w_stateNext;
    logic [ADDR_W-1:0]   r_rs;
    logic [ADDR_W-1:0]   r_rt;
    logic [ADDR_W-1:0]   r_rdLo;
    logic [ADDR_W-1:0]   r_rdHi;
    logic                w_load;
    logic                w_step;
    logic                w_lastStep;
    logic                w_zeroLeft;
    logic [2*DATA_W-1:0] w_product;

    shift_add_unit u_shiftAdd (
        .Clk       (Clk),
        .Rst       (Rst),
        .load      (w_load),
        .step      (w_step),
        .mcandIn   (bus.busX),
        .mplierIn  (bus.busY),
        .lastStep  (w_lastStep),
        .zero_left (w_zeroLeft),
        .product   (w_product)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Request fields are frozen at acceptance so later input changes are inert
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_rs   <= '0;
            r_rt   <= '0;
            r_rdLo <= '0;
            r_rdHi <= '0;
        end else if (r_state == IDLE && bus.start) begin
            r_rs   <= bus.rs;
            r_rt   <= bus.rt;
            r_rdLo <= bus.rd_lo;
            r_rdHi <= bus.rd_hi;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            IDLE:  if (bus.start) w_stateNext = LOAD;
            LOAD: begin
                w_load      = 1'b1;
                w_stateNext = MUL;
            end
            MUL: begin
                w_step = 1'b1;
                if (w_lastStep || w_zeroLeft) w_stateNext = WR_LO;
            end
            WR_LO: w_stateNext = WR_HI;
            WR_HI: w_stateNext = DONE;
            DONE:  w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    always_comb begin
        bus.RX   = '0;
        bus.RY   = '0;
        bus.WEN  = 1'b0;
        bus.RW   = '0;
        bus.busW = '0;
        bus.busy = (r_state != IDLE);
        bus.done = (r_state == DONE);
        case (r_state)
            LOAD: begin
                bus.RX = r_rs;
                bus.RY = r_rt;
            end
            WR_LO: begin
                bus.WEN  = 1'b1;
                bus.RW   = r_rdLo;
                bus.busW = w_product[DATA_W-1:0];
            end
            WR_HI: begin
                bus.WEN  = 1'b1;
                bus.RW   = r_rdHi;
                bus.busW = w_product[2*DATA_W-1:DATA_W];
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_rf_seq_multiplier.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rf_seq_multiplier : regfile model plus write/done scoreboard          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_rf_seq_multiplier;
    import rf_mul_pkg::*;

    typedef struct {
        logic [2:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        int k0;
        int lat;
    } dn_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   doneCount = 0;
    int   busyRun = 0;
    logic [7:0] rf [8];
    wr_t  wq[$];
    dn_t  dq[$];
    wr_t  ew;
    dn_t  ed;
    int   lat;

    rf_mul_if mif ();

    rf_seq_multiplier dut (
        .Clk (clk),
        .Rst (rst),
        .bus (mif.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mif.busX = (mif.RX == 3'd0) ? 8'h00 : rf[mif.RX];
    assign mif.busY = (mif.RY == 3'd0) ? 8'h00 : rf[mif.RY];

    always @(posedge clk) begin
        if (mif.WEN && mif.RW != 3'd0) rf[mif.RW] <= mif.busW;
    end

    // Monitor: pops expectations whenever the DUT writes or signals done
    always @(negedge clk) begin
        if (rst) begin
            busyRun = 0;
        end else begin
            if (mif.busy) busyRun++;
            else          busyRun = 0;
            if (mif.WEN) begin
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write got RW=%0d busW=%02h required no write", mif.RW, mif.busW);
                end else begin
                    ew = wq.pop_front();
                    if (mif.RW !== ew.addr || mif.busW !== ew.data) begin
                        errors++;
                        $display("FAIL write got RW=%0d busW=%02h required RW=%0d busW=%02h",
                                 mif.RW, mif.busW, ew.addr, ew.data);
                    end
                end
            end
            if (mif.done) begin
                doneCount++;
                checks++;
                if (dq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done at cyc %0d required no done", cyc);
                end else begin
                    ed  = dq.pop_front();
                    lat = cyc - ed.k0 + 1;
                    if (lat != ed.lat || busyRun != ed.lat) begin
                        errors++;
                        $display("FAIL done_timing got done_cycle=%0d busy_cycles=%0d required %0d",
                                 lat, busyRun, ed.lat);
                    end
                end
            end
        end
    end

    function automatic int expLat(input logic [7:0] m);
        int hb = 1;
        for (int i = 0; i < 8; i++) if (m[i]) hb = i + 1;
`ifdef MUL_EARLY_TERM_EN
        return 4 + hb;
`else
        return (hb > 0) ? 12 : 12;
`endif
    endfunction

    task automatic launch(input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] lo,
                          input logic [2:0] hi, input logic [7:0] expLo, input logic [7:0] expHi,
                          input int expL, input bit track);
        @(negedge clk); #1;
        if (track) begin
            wq.push_back(wr_t'{lo, expLo});
            wq.push_back(wr_t'{hi, expHi});
            dq.push_back(dn_t'{cyc + 1, expL});
        end
        mif.start = 1'b1;
        mif.rs    = rs;
        mif.rt    = rt;
        mif.rd_lo = lo;
        mif.rd_hi = hi;
        @(negedge clk); #1;
        mif.start = 1'b0;
        mif.rs    = ~rs;
        mif.rt    = ~rt;
        mif.rd_lo = ~lo;
        mif.rd_hi = ~hi;
    endtask

    task automatic waitDone();
        int s = doneCount;
        int n = 0;
        while (doneCount == s && n < 60) begin
            @(negedge clk); #1;
            n++;
        end
        if (doneCount == s) begin
            checks++;
            errors++;
            $display("FAIL done_timeout got no done in %0d cycles required done", n);
        end
    endtask

    task automatic chkReg(input logic [2:0] a, input logic [7:0] exp, input string name);
        checks++;
        if (rf[a] !== exp) begin
            errors++;
            $display("FAIL %s got R%0d=%02h required %02h", name, a, rf[a], exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        mif.start = 1'b0;
        mif.rs    = '0;
        mif.rt    = '0;
        mif.rd_lo = '0;
        mif.rd_hi = '0;
        for (int i = 0; i < 8; i++) rf[i] = 8'h00;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({mif.RX, mif.RY, mif.WEN, mif.RW, mif.busW, mif.busy, mif.done} !== '0) begin
            errors++;
            $display("FAIL reset_state got WEN=%b busy=%b done=%b busW=%02h required all 0",
                     mif.WEN, mif.busy, mif.done, mif.busW);
        end
        rst = 1'b0;
        rf[1] = 8'h6B;
        rf[5] = 8'hE3;

        // 0x6B * 0xE3 = 0x5EE1
        launch(3'd1, 3'd5, 3'd2, 3'd3, 8'hE1, 8'h5E, expLat(8'hE3), 1'b1);
        waitDone();
        chkReg(3'd2, 8'hE1, "t1_lo");
        chkReg(3'd3, 8'h5E, "t1_hi");

        // 0x92 * 0xB5 = 0x673A, destination overlaps a source
        @(negedge clk); #1;
        rf[2] = 8'h92;
        rf[4] = 8'hB5;
        launch(3'd2, 3'd4, 3'd4, 3'd6, 8'h3A, 8'h67, expLat(8'hB5), 1'b1);
        waitDone();
        chkReg(3'd4, 8'h3A, "t2_lo");
        chkReg(3'd6, 8'h67, "t2_hi");

        // 0xFF squared = 0xFE01, same destination keeps the high half
        @(negedge clk); #1;
        rf[7] = 8'hFF;
        launch(3'd7, 3'd7, 3'd1, 3'd1, 8'h01, 8'hFE, expLat(8'hFF), 1'b1);
        waitDone();
        chkReg(3'd1, 8'hFE, "t3_same_dest");

        // R0 source gives zero; an extra start in cycle 4 must be dropped
        launch(3'd0, 3'd5, 3'd2, 3'd3, 8'h00, 8'h00, expLat(8'hE3), 1'b1);
        repeat (3) begin
            @(negedge clk); #1;
        end
        mif.start = 1'b1;
        mif.rs    = 3'd7;
        mif.rt    = 3'd7;
        mif.rd_lo = 3'd5;
        mif.rd_hi = 3'd5;
        @(negedge clk); #1;
        mif.start = 1'b0;
        waitDone();
        repeat (20) @(negedge clk);
        #1;
        chkReg(3'd2, 8'h00, "t4_lo");
        chkReg(3'd3, 8'h00, "t4_hi");
        chkReg(3'd5, 8'hE3, "t4_ignored_start");

        // 0x74 * 0x03 = 0x015C, short multiplier
        rf[1] = 8'h74;
        rf[2] = 8'h03;
        launch(3'd1, 3'd2, 3'd3, 3'd4, 8'h5C, 8'h01, expLat(8'h03), 1'b1);
        waitDone();
        chkReg(3'd3, 8'h5C, "t5_lo");
        chkReg(3'd4, 8'h01, "t5_hi");

        // Reset in cycle 5 of a multiply
        launch(3'd3, 3'd4, 3'd6, 3'd7, 8'h00, 8'h00, 0, 1'b0);
        repeat (4) begin
            @(negedge clk); #1;
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (mif.WEN !== 1'b0 || mif.busy !== 1'b0 || mif.done !== 1'b0 || mif.busW !== 8'h00) begin
            errors++;
            $display("FAIL async_reset got WEN=%b busy=%b done=%b busW=%02h required 0",
                     mif.WEN, mif.busy, mif.done, mif.busW);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        rst = 1'b0;
        repeat (15) @(negedge clk);
        #1;
        chkReg(3'd6, 8'h67, "t6_lo_kept");
        chkReg(3'd7, 8'hFF, "t6_hi_kept");

        // 0x74 * 0xE3 = 0x66DC after reset
        launch(3'd1, 3'd5, 3'd6, 3'd7, 8'hDC, 8'h66, expLat(8'hE3), 1'b1);
        waitDone();
        chkReg(3'd6, 8'hDC, "t7_lo");
        chkReg(3'd7, 8'h66, "t7_hi");

        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (wq.size() != 0 || dq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got writes=%0d dones=%0d pending required 0",
                     wq.size(), dq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
